// File: rtl/stream_demux_reg.sv
// Registered 1-to-N valid/ready demultiplexer with a single-entry output buffer.
// Items whose select names no channel are dropped and counted.
module stream_demux_reg #(
  parameter int W     = 8,
  parameter int N_OUT = 4,
  parameter int CNT_W = 8,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [W-1:0]     up_data,
  input  logic [SEL_W-1:0] up_sel,
  output logic [N_OUT-1:0] down_valid,
  input  logic [N_OUT-1:0] down_ready,
  output logic [W-1:0]     down_data,
  output logic             bad_sel,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [SEL_W:0] N_OUT_EXT = (SEL_W + 1)'(N_OUT);

  logic             full_q;
  logic [SEL_W-1:0] dest_q;
  logic [W-1:0]     data_q;
  logic             drain;
  logic             accept;
  logic             sel_ok;

  always_comb begin
    down_valid = '0;
    for (int i = 0; i < N_OUT; i++) begin
      down_valid[i] = full_q && (dest_q == SEL_W'(i));
    end
  end

  // Only the addressed channel's ready can drain the buffer.
  assign drain     = |(down_valid & down_ready);
  assign up_ready  = !full_q || drain;
  assign accept    = up_valid && up_ready;
  assign sel_ok    = {1'b0, up_sel} < N_OUT_EXT;
  assign down_data = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= 1'b0;
      dest_q   <= '0;
      data_q   <= '0;
      bad_sel  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      bad_sel <= 1'b0;
      if (accept && sel_ok) begin
        full_q <= 1'b1;
        dest_q <= up_sel;
        data_q <= up_data;
      end else begin
        if (drain) begin
          full_q <= 1'b0;
        end
        if (accept) begin
          bad_sel <= 1'b1;
          if (drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_reg.sv
// Self-checking bench for stream_demux_reg: directed scenarios on a 4-channel
// instance plus randomized traffic on a 3-channel instance with a narrow counter.
module tb_stream_demux_reg;

  logic clk = 1'b0;
  logic rst;

  logic       up_valid;
  logic       up_ready;
  logic [7:0] up_data;
  logic [1:0] up_sel;
  logic [3:0] down_valid;
  logic [3:0] down_ready;
  logic [7:0] down_data;
  logic       bad_sel;
  logic [7:0] drop_cnt;

  logic       up_valid3;
  logic       up_ready3;
  logic [7:0] up_data3;
  logic [1:0] up_sel3;
  logic [2:0] down_valid3;
  logic [2:0] down_ready3;
  logic [7:0] down_data3;
  logic       bad_sel3;
  logic [1:0] drop_cnt3;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } item_t;

  always #5 clk = ~clk;

  stream_demux_reg #(.W(8), .N_OUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_sel(up_sel),
    .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data),
    .bad_sel(bad_sel), .drop_cnt(drop_cnt)
  );

  stream_demux_reg #(.W(8), .N_OUT(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst),
    .up_valid(up_valid3), .up_ready(up_ready3), .up_data(up_data3), .up_sel(up_sel3),
    .down_valid(down_valid3), .down_ready(down_ready3), .down_data(down_data3),
    .bad_sel(bad_sel3), .drop_cnt(drop_cnt3)
  );

  task automatic test_reset();
    rst = 1'b1;
    up_valid = 1'b0; up_data = '0; up_sel = '0; down_ready = 4'b1111;
    up_valid3 = 1'b0; up_data3 = '0; up_sel3 = '0; down_ready3 = 3'b111;
    repeat (2) @(negedge clk);
    checks++;
    if (down_valid !== 4'b0000) $display("[TB] FAIL reset_dv_held: got %b expected 0000", down_valid);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (up_ready !== 1'b1) $display("[TB] FAIL reset_up_ready: got %b expected 1", up_ready);
    else passed++;
    checks++;
    if (down_valid !== 4'b0000) $display("[TB] FAIL reset_dv: got %b expected 0000", down_valid);
    else passed++;
    checks++;
    if (drop_cnt !== 8'd0) $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
    else passed++;
    checks++;
    if (bad_sel !== 1'b0) $display("[TB] FAIL reset_bad_sel: got %b expected 0", bad_sel);
    else passed++;
  endtask

  task automatic test_stream();
    logic [7:0] data_tab [4];
    data_tab = '{8'h11, 8'h22, 8'h33, 8'h44};
    down_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (down_valid !== 4'(1 << (k - 1)))
          $display("[TB] FAIL stream_dv[%0d]: got %b expected %b", k - 1, down_valid, 4'(1 << (k - 1)));
        else passed++;
        checks++;
        if (down_data !== data_tab[k - 1])
          $display("[TB] FAIL stream_data[%0d]: got %h expected %h", k - 1, down_data, data_tab[k - 1]);
        else passed++;
      end
      if (k < 4) begin
        up_valid = 1'b1;
        up_data  = data_tab[k];
        up_sel   = k[1:0];
      end else begin
        up_valid = 1'b0;
      end
      #1;
      checks++;
      if (up_ready !== 1'b1) $display("[TB] FAIL stream_up_ready[%0d]: got %b expected 1", k, up_ready);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (down_valid !== 4'b0000) $display("[TB] FAIL stream_idle_dv: got %b expected 0000", down_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    down_ready = 4'b1011;
    @(negedge clk);
    up_valid = 1'b1; up_data = 8'hA5; up_sel = 2'd2;
    @(negedge clk);
    up_data = 8'h5A; up_sel = 2'd0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (down_valid !== 4'b0100) $display("[TB] FAIL bp_hold_dv[%0d]: got %b expected 0100", k, down_valid);
      else passed++;
      checks++;
      if (down_data !== 8'hA5) $display("[TB] FAIL bp_hold_data[%0d]: got %h expected a5", k, down_data);
      else passed++;
      checks++;
      if (up_ready !== 1'b0) $display("[TB] FAIL bp_hold_up_ready[%0d]: got %b expected 0", k, up_ready);
      else passed++;
    end
    @(negedge clk);
    down_ready = 4'b1111;
    #1;
    checks++;
    if (up_ready !== 1'b1) $display("[TB] FAIL bp_release_up_ready: got %b expected 1", up_ready);
    else passed++;
    @(negedge clk);
    up_valid = 1'b0;
    checks++;
    if (down_valid !== 4'b0001) $display("[TB] FAIL bp_next_dv: got %b expected 0001", down_valid);
    else passed++;
    checks++;
    if (down_data !== 8'h5A) $display("[TB] FAIL bp_next_data: got %h expected 5a", down_data);
    else passed++;
    @(negedge clk);
    checks++;
    if (down_valid !== 4'b0000) $display("[TB] FAIL bp_idle_dv: got %b expected 0000", down_valid);
    else passed++;
  endtask

  task automatic test_bad_sel();
    down_ready3 = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (bad_sel3 !== 1'b1) $display("[TB] FAIL badsel_pulse[%0d]: got %b expected 1", k, bad_sel3);
        else passed++;
        checks++;
        if (drop_cnt3 !== 2'((k > 3) ? 3 : k))
          $display("[TB] FAIL badsel_drop_cnt[%0d]: got %0d expected %0d", k, drop_cnt3, (k > 3) ? 3 : k);
        else passed++;
        checks++;
        if (down_valid3 !== 3'b000) $display("[TB] FAIL badsel_dv[%0d]: got %b expected 000", k, down_valid3);
        else passed++;
      end
      if (k < 5) begin
        up_valid3 = 1'b1;
        up_sel3   = 2'd3;
        up_data3  = 8'($urandom);
        #1;
        checks++;
        if (up_ready3 !== 1'b1) $display("[TB] FAIL badsel_up_ready[%0d]: got %b expected 1", k, up_ready3);
        else passed++;
      end else begin
        up_valid3 = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (bad_sel3 !== 1'b0) $display("[TB] FAIL badsel_quiet: got %b expected 0", bad_sel3);
    else passed++;
    checks++;
    if (drop_cnt3 !== 2'd3) $display("[TB] FAIL badsel_final_cnt: got %0d expected 3", drop_cnt3);
    else passed++;
  endtask

  task automatic test_reset_mid();
    down_ready = 4'b0000;
    @(negedge clk);
    up_valid = 1'b1; up_data = 8'hC3; up_sel = 2'd1;
    @(negedge clk);
    up_valid = 1'b0;
    checks++;
    if (down_valid !== 4'b0010) $display("[TB] FAIL rstmid_loaded_dv: got %b expected 0010", down_valid);
    else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (down_valid !== 4'b0000) $display("[TB] FAIL rstmid_async_dv: got %b expected 0000", down_valid);
    else passed++;
    checks++;
    if (down_data !== 8'h00) $display("[TB] FAIL rstmid_async_data: got %h expected 00", down_data);
    else passed++;
    #4 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (up_ready !== 1'b1) $display("[TB] FAIL rstmid_up_ready: got %b expected 1", up_ready);
    else passed++;
    down_ready = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (down_valid !== 4'b0000) $display("[TB] FAIL rstmid_no_delivery[%0d]: got %b expected 0000", k, down_valid);
      else passed++;
    end
  endtask

  // Capacity-one pipe modelled as a FIFO of pending items; acceptance and
  // draining are decided from the model's own occupancy, not the DUT's.
  task automatic test_random();
    item_t      pending [$];
    item_t      it;
    int         drops = 0;
    int         accepted = 0;
    int         cycles = 0;
    int         idle_cycles = 0;
    logic       exp_bad = 1'b0;
    logic [2:0] exp_dv;
    logic       drain_exp;
    logic       ready_exp;
    @(negedge clk);
    rst = 1'b1;
    up_valid3 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    while (idle_cycles < 4) begin
      @(negedge clk);
      cycles++;
      if (cycles > 60000) begin
        checks++;
        $display("[TB] FAIL random_timeout: got %0d accepted expected 10000", accepted);
        break;
      end
      exp_dv = 3'b000;
      if (pending.size() > 0) exp_dv[pending[0].ch] = 1'b1;
      checks++;
      if (down_valid3 !== exp_dv) $display("[TB] FAIL random_dv@%0d: got %b expected %b", cycles, down_valid3, exp_dv);
      else passed++;
      if (pending.size() > 0) begin
        checks++;
        if (down_data3 !== pending[0].data)
          $display("[TB] FAIL random_data@%0d: got %h expected %h", cycles, down_data3, pending[0].data);
        else passed++;
      end
      checks++;
      if (bad_sel3 !== exp_bad) $display("[TB] FAIL random_bad_sel@%0d: got %b expected %b", cycles, bad_sel3, exp_bad);
      else passed++;
      checks++;
      if (drop_cnt3 !== 2'((drops > 3) ? 3 : drops))
        $display("[TB] FAIL random_drop_cnt@%0d: got %0d expected %0d", cycles, drop_cnt3, (drops > 3) ? 3 : drops);
      else passed++;

      if (accepted < 10000) begin
        up_valid3   = ($urandom_range(3) != 0);
        up_sel3     = 2'($urandom_range(3));
        up_data3    = 8'($urandom);
        down_ready3 = 3'($urandom);
      end else begin
        up_valid3   = 1'b0;
        down_ready3 = 3'b111;
        if (pending.size() == 0) idle_cycles++;
      end
      #1;
      drain_exp = (pending.size() > 0) && down_ready3[pending[0].ch];
      ready_exp = (pending.size() == 0) || drain_exp;
      checks++;
      if (up_ready3 !== ready_exp) $display("[TB] FAIL random_up_ready@%0d: got %b expected %b", cycles, up_ready3, ready_exp);
      else passed++;

      if (drain_exp) void'(pending.pop_front());
      exp_bad = 1'b0;
      if (up_valid3 && ready_exp) begin
        accepted++;
        if (up_sel3 < 2'd3) begin
          it.ch   = int'(up_sel3);
          it.data = up_data3;
          pending.push_back(it);
        end else begin
          drops++;
          exp_bad = 1'b1;
        end
      end
    end
    checks++;
    if (pending.size() != 0) $display("[TB] FAIL random_leftover: got %0d items expected 0", pending.size());
    else passed++;
    $display("[TB] random traffic: %0d accepted, %0d dropped, %0d cycles", accepted, drops, cycles);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bad_sel();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
